// File: rtl/regfile_wb_queue.sv
// Write-back queue for the 16x16 register file: in-order FIFO with youngest-value read bypass.
// Optional macro WBQ_STATS_EN builds the saturating wb stall counter; otherwise stall_cnt is zero.
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mf_valid,
    output logic              mf_ready,
    input  logic [REG_W-1:0]  mf_reg,
    input  logic [DATA_W-1:0] mf_data,
    output logic [REG_W-1:0]  DstReg,
    output logic              WriteReg,
    output logic [DATA_W-1:0] DstData,
    input  logic [REG_W-1:0]  SrcReg1,
    input  logic [REG_W-1:0]  SrcReg2,
    output logic              byp_hit1,
    output logic [DATA_W-1:0] byp_data1,
    output logic              byp_hit2,
    output logic [DATA_W-1:0] byp_data2,
    output logic [15:0]       stall_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

    logic [REG_W-1:0]  r_q_reg  [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_nonempty;
    logic [CNT_W:0]    w_free;
    logic              w_wb_push;
    logic              w_mf_push;
    logic [PTR_W-1:0]  w_mf_slot;

    assign w_nonempty = (r_count != '0);

    // The head always leaves this cycle, so its slot counts as free for incoming requests.
    assign w_free   = DEPTH_V - {1'b0, r_count} + {{CNT_W{1'b0}}, w_nonempty};
    assign wb_ready = (w_free >= (CNT_W+1)'(1));
    assign mf_ready = (w_free >= ((CNT_W+1)'(1) + {{CNT_W{1'b0}}, wb_valid}));

    assign w_wb_push = wb_valid & wb_ready & (wb_reg != '0);
    assign w_mf_push = mf_valid & mf_ready & (mf_reg != '0);
    assign w_mf_slot = r_wr_ptr + PTR_W'(w_wb_push);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_nonempty);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_wb_push) + PTR_W'(w_mf_push);
            r_count  <= r_count + CNT_W'(w_wb_push) + CNT_W'(w_mf_push) - CNT_W'(w_nonempty);
        end
    end

    // Storage needs no reset: entries are only observed while covered by r_count.
    always_ff @(posedge clk) begin
        if (w_wb_push) begin
            r_q_reg[r_wr_ptr]  <= wb_reg;
            r_q_data[r_wr_ptr] <= wb_data;
        end
        if (w_mf_push) begin
            r_q_reg[w_mf_slot]  <= mf_reg;
            r_q_data[w_mf_slot] <= mf_data;
        end
    end

    assign WriteReg = w_nonempty;
    assign DstReg   = w_nonempty ? r_q_reg[r_rd_ptr]  : '0;
    assign DstData  = w_nonempty ? r_q_data[r_rd_ptr] : '0;

    // Scan oldest to youngest so the last match leaves the youngest data.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < r_count) begin
                if ((SrcReg1 != '0) && (r_q_reg[PTR_W'(r_rd_ptr + PTR_W'(i))] == SrcReg1)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = r_q_data[PTR_W'(r_rd_ptr + PTR_W'(i))];
                end
                if ((SrcReg2 != '0) && (r_q_reg[PTR_W'(r_rd_ptr + PTR_W'(i))] == SrcReg2)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = r_q_data[PTR_W'(r_rd_ptr + PTR_W'(i))];
                end
            end
        end
    end

`ifdef WBQ_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (wb_valid && !wb_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus random traffic against a queue-based model.
// Define WBQ_STATS_EN for both bench and design to exercise the stall counter.
module tb_regfile_wb_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wb_valid = 1'b0;
    logic              wb_ready;
    logic [REG_W-1:0]  wb_reg = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              mf_valid = 1'b0;
    logic              mf_ready;
    logic [REG_W-1:0]  mf_reg = '0;
    logic [DATA_W-1:0] mf_data = '0;
    logic [REG_W-1:0]  DstReg;
    logic              WriteReg;
    logic [DATA_W-1:0] DstData;
    logic [REG_W-1:0]  SrcReg1 = '0;
    logic [REG_W-1:0]  SrcReg2 = '0;
    logic              byp_hit1;
    logic [DATA_W-1:0] byp_data1;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data2;
    logic [15:0]       stall_cnt;

    regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
        .mf_valid(mf_valid), .mf_ready(mf_ready), .mf_reg(mf_reg), .mf_data(mf_data),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1),
        .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned m_stall = 0;

    function automatic int m_free();
        return DEPTH - q.size() + ((q.size() != 0) ? 1 : 0);
    endfunction

    function automatic logic m_wb_ready();
        return m_free() >= 1;
    endfunction

    function automatic logic m_mf_ready();
        return m_free() >= (1 + (wb_valid ? 1 : 0));
    endfunction

    function automatic logic m_hit(logic [REG_W-1:0] s);
        if (s == 0) return 1'b0;
        foreach (q[i]) if (q[i].r == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] m_data(logic [REG_W-1:0] s);
        logic [DATA_W-1:0] v = '0;
        if (s != 0) foreach (q[i]) if (q[i].r == s) v = q[i].d;
        return v;
    endfunction

    // Advance one clock: model reacts to the inputs present at the edge. Ends on the falling edge.
    task automatic step();
        logic wa, ma;
        ent_t we, me;
        wa = wb_valid && m_wb_ready();
        ma = mf_valid && m_mf_ready();
        we = {wb_reg, wb_data};
        me = {mf_reg, mf_data};
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_stall = 0;
        end else begin
            if (q.size() != 0) void'(q.pop_front());
            if (wb_valid && !wa && m_stall != 32'hFFFF) m_stall++;
            if (wa && we.r != 0) q.push_back(we);
            if (ma && me.r != 0) q.push_back(me);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0;
        mf_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        #1;
        checks++;
        if ({WriteReg, DstReg, DstData} !== '0)
            begin errors++; $display("FAIL reset_write_port: got %b/%h/%h required 0/0/0", WriteReg, DstReg, DstData); end
        checks++;
        if ({byp_hit1, byp_data1, byp_hit2, byp_data2} !== '0)
            begin errors++; $display("FAIL reset_bypass: got %b %h %b %h required all zero", byp_hit1, byp_data1, byp_hit2, byp_data2); end
        checks++;
        if ({wb_ready, mf_ready} !== 2'b11)
            begin errors++; $display("FAIL reset_ready: got wb=%b mf=%b required 1 1", wb_ready, mf_ready); end
        checks++;
        if (stall_cnt !== 16'h0000)
            begin errors++; $display("FAIL reset_stall: got %h required 0000", stall_cnt); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_wb();
        wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 16'h1234; SrcReg1 = 4'd3;
        #1;
        checks++;
        if (byp_hit1 !== 1'b0)
            begin errors++; $display("FAIL single_not_visible: byp_hit1 got %b required 0", byp_hit1); end
        step();
        idle_inputs();
        #1;
        checks++;
        if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd3, 16'h1234})
            begin errors++; $display("FAIL single_write: got %b/%h/%h required 1/3/1234", WriteReg, DstReg, DstData); end
        checks++;
        if ({byp_hit1, byp_data1} !== {1'b1, 16'h1234})
            begin errors++; $display("FAIL single_bypass: got %b/%h required 1/1234", byp_hit1, byp_data1); end
        step();
        #1;
        checks++;
        if ({WriteReg, byp_hit1} !== 2'b00)
            begin errors++; $display("FAIL single_drained: WriteReg/hit got %b/%b required 0/0", WriteReg, byp_hit1); end
    endtask

    task automatic test_same_dest();
        wb_valid = 1'b1; wb_reg = 4'd5; wb_data = 16'hAAAA;
        mf_valid = 1'b1; mf_reg = 4'd5; mf_data = 16'h5555;
        SrcReg2 = 4'd5;
        #1;
        checks++;
        if ({wb_ready, mf_ready} !== 2'b11)
            begin errors++; $display("FAIL same_ready: got wb=%b mf=%b required 1 1", wb_ready, mf_ready); end
        step();
        idle_inputs();
        #1;
        checks++;
        if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd5, 16'hAAAA})
            begin errors++; $display("FAIL same_first: got %b/%h/%h required 1/5/aaaa", WriteReg, DstReg, DstData); end
        checks++;
        if ({byp_hit2, byp_data2} !== {1'b1, 16'h5555})
            begin errors++; $display("FAIL same_youngest: got %b/%h required 1/5555", byp_hit2, byp_data2); end
        step();
        #1;
        checks++;
        if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd5, 16'h5555})
            begin errors++; $display("FAIL same_second: got %b/%h/%h required 1/5/5555", WriteReg, DstReg, DstData); end
        step();
        #1;
        checks++;
        if (WriteReg !== 1'b0)
            begin errors++; $display("FAIL same_empty: WriteReg got %b required 0", WriteReg); end
    endtask

    task automatic test_r0();
        wb_valid = 1'b1; wb_reg = 4'd0; wb_data = 16'hFFFF; SrcReg1 = 4'd0;
        #1;
        checks++;
        if (wb_ready !== 1'b1)
            begin errors++; $display("FAIL r0_ready: got %b required 1", wb_ready); end
        step();
        idle_inputs();
        #1;
        checks++;
        if ({WriteReg, byp_hit1} !== 2'b00)
            begin errors++; $display("FAIL r0_no_write: WriteReg/hit got %b/%b required 0/0", WriteReg, byp_hit1); end
    endtask

    task automatic test_fill();
        ent_t exp[$];
        ent_t obs[$];
        bit   saw_block = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            wb_valid = 1'b1; wb_reg = 4'($urandom_range(1, 15)); wb_data = 16'($urandom);
            mf_valid = 1'b1; mf_reg = 4'($urandom_range(1, 15)); mf_data = 16'($urandom);
            #1;
            checks++;
            if (mf_ready !== m_mf_ready())
                begin errors++; $display("FAIL fill_mf_ready cycle %0d: got %b required %b", c, mf_ready, m_mf_ready()); end
            if (!m_mf_ready()) saw_block = 1'b1;
            if (WriteReg) obs.push_back({DstReg, DstData});
            if (m_wb_ready()) exp.push_back({wb_reg, wb_data});
            if (m_mf_ready()) exp.push_back({mf_reg, mf_data});
            step();
        end
        idle_inputs();
        for (int c = 0; c < 4 * DEPTH; c++) begin
            #1;
            if (WriteReg) obs.push_back({DstReg, DstData});
            step();
        end
        checks++;
        if (!saw_block)
            begin errors++; $display("FAIL fill_block: mf_ready never required to drop"); end
        checks++;
        if (obs.size() != exp.size())
            begin errors++; $display("FAIL fill_count: got %0d writes required %0d", obs.size(), exp.size()); end
        else
            foreach (exp[i]) begin
                checks++;
                if (obs[i] !== exp[i])
                    begin errors++; $display("FAIL fill_order[%0d]: got %h/%h required %h/%h", i, obs[i].r, obs[i].d, exp[i].r, exp[i].d); end
            end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            wb_valid = 1'b1; wb_reg = 4'd7; wb_data = 16'($urandom);
            mf_valid = 1'b1; mf_reg = 4'd9; mf_data = 16'($urandom);
            step();
        end
        idle_inputs();
        SrcReg1 = 4'd7;
        #1;
        checks++;
        if ({WriteReg, byp_hit1} !== 2'b11 || q.size() != 3)
            begin errors++; $display("FAIL midrst_setup: WriteReg/hit got %b/%b required 1/1 with 3 queued (model %0d)", WriteReg, byp_hit1, q.size()); end
        rst = 1'b0;
        step();
        #1;
        checks++;
        if ({WriteReg, byp_hit1} !== 2'b00)
            begin errors++; $display("FAIL midrst_flush: WriteReg/hit got %b/%b required 0/0", WriteReg, byp_hit1); end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (WriteReg !== 1'b0)
                begin errors++; $display("FAIL midrst_quiet cycle %0d: WriteReg got %b required 0", c, WriteReg); end
            step();
        end
        checks++;
        if (stall_cnt !== 16'h0000)
            begin errors++; $display("FAIL midrst_stall: got %h required 0000", stall_cnt); end
    endtask

    task automatic test_random();
        logic [REG_W-1:0]  e_reg;
        logic [DATA_W-1:0] e_data;
        for (int c = 0; c < 300; c++) begin
            wb_valid = ($urandom_range(0, 3) != 0);
            wb_reg   = 4'($urandom_range(0, 15));
            wb_data  = 16'($urandom);
            mf_valid = ($urandom_range(0, 2) != 0);
            mf_reg   = 4'($urandom_range(0, 15));
            mf_data  = 16'($urandom);
            SrcReg1  = 4'($urandom_range(0, 15));
            SrcReg2  = (q.size() != 0 && $urandom_range(0, 1) == 1) ? q[q.size() - 1].r : 4'($urandom_range(0, 15));
            #1;
            e_reg  = (q.size() != 0) ? q[0].r : '0;
            e_data = (q.size() != 0) ? q[0].d : '0;
            checks++;
            if ({WriteReg, DstReg, DstData} !== {q.size() != 0, e_reg, e_data})
                begin errors++; $display("FAIL rand_write c%0d: got %b/%h/%h required %b/%h/%h", c, WriteReg, DstReg, DstData, q.size() != 0, e_reg, e_data); end
            checks++;
            if ({wb_ready, mf_ready} !== {m_wb_ready(), m_mf_ready()})
                begin errors++; $display("FAIL rand_ready c%0d: got %b%b required %b%b", c, wb_ready, mf_ready, m_wb_ready(), m_mf_ready()); end
            checks++;
            if ({byp_hit1, byp_data1} !== {m_hit(SrcReg1), m_data(SrcReg1)})
                begin errors++; $display("FAIL rand_byp1 c%0d src %0d: got %b/%h required %b/%h", c, SrcReg1, byp_hit1, byp_data1, m_hit(SrcReg1), m_data(SrcReg1)); end
            checks++;
            if ({byp_hit2, byp_data2} !== {m_hit(SrcReg2), m_data(SrcReg2)})
                begin errors++; $display("FAIL rand_byp2 c%0d src %0d: got %b/%h required %b/%h", c, SrcReg2, byp_hit2, byp_data2, m_hit(SrcReg2), m_data(SrcReg2)); end
`ifdef WBQ_STATS_EN
            checks++;
            if (stall_cnt !== 16'(m_stall))
                begin errors++; $display("FAIL rand_stall c%0d: got %0d required %0d", c, stall_cnt, m_stall); end
`else
            checks++;
            if (stall_cnt !== 16'h0000)
                begin errors++; $display("FAIL rand_stall c%0d: got %h required 0000", c, stall_cnt); end
`endif
            checks++;
            if (q.size() > DEPTH)
                begin errors++; $display("FAIL rand_occupancy c%0d: model holds %0d entries, limit %0d", c, q.size(), DEPTH); end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_wb();
        test_same_dest();
        test_r0();
        test_fill();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
